// File: rtl/gpio_in_filter.sv
// Per-pin synchronizer + tick-based debouncer with rise/fall event pulses.
// Latency: 2 + STABLE_COUNT*PRESCALE cycles worst case; 3 cycles in bypass.
// No backpressure: outputs are free-running levels and single-cycle pulses.
module gpio_in_filter #(
  parameter int WIDTH        = 32,
  parameter int PRESCALE     = 100,
  parameter int STABLE_COUNT = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [WIDTH-1:0] pins_i,
  input  logic             bypass_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0]         s1;
  logic [WIDTH-1:0]         s2;
  logic                     tick;
  logic [WIDTH-1:0]         lvl_nxt;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_nxt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pins_i;
      s2 <= s1;
    end
  end

  generate
    if (PRESCALE == 1) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      logic [PW-1:0] pcnt;

      assign tick = (pcnt == PW'(PRESCALE - 1));

      always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
          pcnt <= '0;
        end else if (tick) begin
          pcnt <= '0;
        end else begin
          pcnt <= pcnt + PW'(1);
        end
      end
    end
  endgenerate

  // A single tick of agreement with the current level restarts the count.
  always_comb begin
    lvl_nxt = gpio_o;
    cnt_nxt = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      if (bypass_i) begin
        lvl_nxt[i] = s2[i];
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (s2[i] == gpio_o[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          lvl_nxt[i] = s2[i];
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt    <= '0;
      gpio_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      cnt    <= cnt_nxt;
      gpio_o <= lvl_nxt;
      rise_o <= lvl_nxt & ~gpio_o;
      fall_o <= ~lvl_nxt & gpio_o;
    end
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench: u_dut runs PRESCALE=1/STABLE_COUNT=4, u_pre runs PRESCALE=10/STABLE_COUNT=2.
module tb_gpio_in_filter;

  logic        clk;
  logic        rst_n;
  logic [31:0] pins;
  logic [31:0] pins2;
  logic        bypass;
  logic        bypass2;
  logic [31:0] gpio, rise, fall;
  logic [31:0] gpio2, rise2, fall2;

  int n_checks;
  int n_fail;

  gpio_in_filter #(.WIDTH(32), .PRESCALE(1), .STABLE_COUNT(4)) u_dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .pins_i    (pins),
    .bypass_i  (bypass),
    .gpio_o    (gpio),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  gpio_in_filter #(.WIDTH(32), .PRESCALE(10), .STABLE_COUNT(2)) u_pre (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .pins_i    (pins2),
    .bypass_i  (bypass2),
    .gpio_o    (gpio2),
    .rise_o    (rise2),
    .fall_o    (fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pv(int n);
    logic [31:0] v;
    if (n < 0) return 1'b0;
    v = n;
    return v[1];
  endfunction

  task automatic test_reset();
    rst_n   = 1'b1;
    pins    = 32'hFFFF_FFFF;
    pins2   = 32'h0000_0020;
    bypass  = 1'b0;
    bypass2 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (gpio !== 32'h0) begin n_fail++; $display("FAIL reset_gpio: got %h expected %h", gpio, 32'h0); end
    n_checks++;
    if (rise !== 32'h0 || fall !== 32'h0) begin
      n_fail++; $display("FAIL reset_pulses: rise %h fall %h expected 0", rise, fall);
    end
    n_checks++;
    if (gpio2 !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_pre: got %h expected %h", gpio2, 32'h0); end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) begin
        n_checks++;
        if (gpio !== 32'h0) begin n_fail++; $display("FAIL reset_rel_early: got %h expected %h", gpio, 32'h0); end
      end
      if (k == 6) begin
        n_checks++;
        if (gpio !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_rel_gpio: got %h expected %h", gpio, 32'hFFFF_FFFF); end
        n_checks++;
        if (rise !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_rel_rise: got %h expected %h", rise, 32'hFFFF_FFFF); end
      end
      if (k == 7) begin
        n_checks++;
        if (rise !== 32'h0) begin n_fail++; $display("FAIL reset_rel_rise_once: got %h expected %h", rise, 32'h0); end
      end
    end
  endtask

  task automatic test_debounce_accept();
    logic [31:0] fall_seen;
    pins = 32'h0;
    repeat (12) step();
    n_checks++;
    if (gpio !== 32'h0) begin n_fail++; $display("FAIL accept_pre: got %h expected %h", gpio, 32'h0); end
    fall_seen = '0;
    pins[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      fall_seen |= fall;
      if (k == 5) begin
        n_checks++;
        if (gpio !== 32'h0) begin n_fail++; $display("FAIL accept_early: got %h expected %h", gpio, 32'h0); end
      end
      if (k == 6) begin
        n_checks++;
        if (gpio !== 32'h1) begin n_fail++; $display("FAIL accept_gpio: got %h expected %h", gpio, 32'h1); end
        n_checks++;
        if (rise !== 32'h1) begin n_fail++; $display("FAIL accept_rise: got %h expected %h", rise, 32'h1); end
      end
      if (k == 7) begin
        n_checks++;
        if (rise !== 32'h0) begin n_fail++; $display("FAIL accept_rise_once: got %h expected %h", rise, 32'h0); end
      end
    end
    n_checks++;
    if (fall_seen !== 32'h0) begin n_fail++; $display("FAIL accept_no_fall: got %h expected %h", fall_seen, 32'h0); end
    pins = 32'h0;
    repeat (10) step();
  endtask

  task automatic test_glitch();
    logic [31:0] seen;
    seen = '0;
    pins[3] = 1'b1;
    repeat (3) step();
    pins[3] = 1'b0;
    repeat (12) begin
      step();
      seen |= gpio | rise | fall;
    end
    n_checks++;
    if (seen !== 32'h0) begin n_fail++; $display("FAIL glitch_reject: got %h expected %h", seen, 32'h0); end
    pins[3] = 1'b1;
    repeat (4) step();
    pins[3] = 1'b0;
    step();
    n_checks++;
    if (gpio !== 32'h0) begin n_fail++; $display("FAIL glitch4_early: got %h expected %h", gpio, 32'h0); end
    step();
    n_checks++;
    if (gpio !== 32'h8) begin n_fail++; $display("FAIL glitch4_gpio: got %h expected %h", gpio, 32'h8); end
    n_checks++;
    if (rise !== 32'h8) begin n_fail++; $display("FAIL glitch4_rise: got %h expected %h", rise, 32'h8); end
    repeat (10) step();
    n_checks++;
    if (gpio !== 32'h0) begin n_fail++; $display("FAIL glitch4_release: got %h expected %h", gpio, 32'h0); end
  endtask

  task automatic test_prescale();
    int lat;
    int falls;
    logic [31:0] other;
    n_checks++;
    if (gpio2 !== 32'h20) begin n_fail++; $display("FAIL prescale_pre: got %h expected %h", gpio2, 32'h20); end
    lat   = 0;
    falls = 0;
    other = '0;
    pins2[5] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (lat == 0 && gpio2[5] == 1'b0) lat = k;
      if (fall2[5]) begin
        falls++;
        n_checks++;
        if (gpio2[5] !== 1'b0) begin n_fail++; $display("FAIL prescale_pulse_align: gpio %b expected 0", gpio2[5]); end
      end
      other |= (fall2 & ~32'h20) | rise2;
    end
    n_checks++;
    if (lat < 13 || lat > 22) begin n_fail++; $display("FAIL prescale_latency: got %0d expected 13..22", lat); end
    n_checks++;
    if (falls != 1) begin n_fail++; $display("FAIL prescale_fall_count: got %0d expected 1", falls); end
    n_checks++;
    if (other !== 32'h0) begin n_fail++; $display("FAIL prescale_spurious: got %h expected %h", other, 32'h0); end
  endtask

  task automatic test_bypass();
    for (int n = 0; n < 16; n++) begin
      pins[7] = pv(n);
      bypass  = 1'b1;
      step();
      if (n >= 2) begin
        n_checks++;
        if (gpio[7] !== pv(n - 2)) begin
          n_fail++; $display("FAIL bypass_gpio[%0d]: got %b expected %b", n, gpio[7], pv(n - 2));
        end
        n_checks++;
        if (rise[7] !== (pv(n - 2) & ~pv(n - 3)) || fall[7] !== (~pv(n - 2) & pv(n - 3))) begin
          n_fail++; $display("FAIL bypass_pulse[%0d]: rise %b fall %b expected %b %b", n, rise[7], fall[7],
                             pv(n - 2) & ~pv(n - 3), ~pv(n - 2) & pv(n - 3));
        end
      end
    end
    repeat (3) step();
    bypass = 1'b0;
    step();
    n_checks++;
    if (gpio !== 32'h80) begin n_fail++; $display("FAIL bypass_exit_level: got %h expected %h", gpio, 32'h80); end
    pins[7] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) begin
        n_checks++;
        if (gpio[7] !== 1'b1) begin n_fail++; $display("FAIL bypass_resume_early: got %b expected 1", gpio[7]); end
      end
      if (k == 6) begin
        n_checks++;
        if (gpio[7] !== 1'b0 || fall[7] !== 1'b1) begin
          n_fail++; $display("FAIL bypass_resume: gpio %b fall %b expected 0 1", gpio[7], fall[7]);
        end
      end
    end
    repeat (3) step();
  endtask

  task automatic test_reset_midcount();
    logic [31:0] seen;
    pins2   = 32'h0;
    pins[1] = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    seen = gpio | rise | fall;
    repeat (3) begin
      step();
      seen |= gpio | rise | fall;
    end
    n_checks++;
    if (seen !== 32'h0) begin n_fail++; $display("FAIL midreset_outputs: got %h expected %h", seen, 32'h0); end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) begin
        n_checks++;
        if (gpio !== 32'h0) begin n_fail++; $display("FAIL midreset_early: got %h expected %h", gpio, 32'h0); end
      end
      if (k == 6) begin
        n_checks++;
        if (gpio !== 32'h2 || rise !== 32'h2) begin
          n_fail++; $display("FAIL midreset_accept: gpio %h rise %h expected %h %h", gpio, rise, 32'h2, 32'h2);
        end
      end
      if (k == 7) begin
        n_checks++;
        if (rise !== 32'h0) begin n_fail++; $display("FAIL midreset_rise_once: got %h expected %h", rise, 32'h0); end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_debounce_accept();
    test_glitch();
    test_prescale();
    test_bypass();
    test_reset_midcount();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
